bcm_plane_sequencer: RTL and testbench
======================================

# bcm_plane_sequencer

Parametrised binary-code-modulation sequencer for the LED-matrix GPU path. It times each bit plane for `CYCLES_PER_TICK << plane` cycles and generates a runtime-adjustable dimmed display-enable. It handshakes with the plane loader between planes, and either stops after one frame or loops frames continuously until told to stop.

## Interface
Parameters:
- `PLANES`, 4: number of bit planes per frame, 1..8.
- `CYCLES_PER_TICK`, 256: display cycles of the plane-0 slot, ≥1.
- `BRIGHT_W`, 9: width of the brightness input.
- Local `TIMER_W = clog2(CYCLES_PER_TICK << (PLANES-1))`; local `PIDX_W = max(1, clog2(PLANES))`.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_start`  in  1  starts a frame; sampled only in IDLE.
- `in_loop`  in  1  continuous mode; sampled at each frame end.
- `in_stop`  in  1  request to finish the current frame and then halt.
- `in_brightness`  in  BRIGHT_W  dim cycles per tick; larger means dimmer.
- `in_continue`  in  1  loader ack that the requested plane is loaded.
- `out_plane`  out  PIDX_W  index of the plane being shown or requested.
- `out_next_plane`  out  1  one-cycle pulse requesting a load of `out_plane`.
- `out_display`  out  1  panel output-enable.
- `out_busy`  out  1  high whenever the state is not IDLE.
- `out_frame_done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- States: IDLE, DISPLAY, WAIT. Registers: `timer`, `plane`, `bright_l`, `stop_pend`.
- Reset values:
  - state IDLE.
  - `timer`, `plane`, `stop_pend`, `bright_l` all 0.
  - every output 0.
- IDLE:
  - On `in_start`: timer=0, plane=0, stop_pend=0, `bright_l = min(in_brightness, CYCLES_PER_TICK)`; go to DISPLAY.
  - Plane 0 must already be loaded; no request is issued for it.
- DISPLAY:
  - `timer` increments every cycle.
  - `out_display = (timer < ((CYCLES_PER_TICK - bright_l) << plane))`.
  - When `timer == (CYCLES_PER_TICK << plane) - 1`, set timer=0, then:
    - If `plane < PLANES-1`: plane+1, pulse `out_next_plane`, go to WAIT.
    - Else (last plane): pulse `out_frame_done`.
      - If `in_loop` and no stop (`stop_pend` clear and `in_stop` low this cycle): plane=0, re-latch `bright_l`, pulse `out_next_plane`, go to WAIT.
      - Otherwise go to IDLE.
- WAIT:
  - `out_display`=0 and timer frozen at 0.
  - On `in_continue`, go to DISPLAY.
  - `in_continue` is ignored in every state except WAIT.
- `in_stop` while busy sets `stop_pend`, which clears on entry to IDLE. Stop never truncates a frame. `in_stop` in IDLE has no effect.
- `in_brightness` changes take effect only at a latch point (start, or a loop restart).
- Arithmetic:
  - Compares use `TIMER_W` bits.
  - `bright_l` saturates at `CYCLES_PER_TICK`. At saturation `out_display` is never high, but slot timing is unchanged.
- `in_start` while busy is ignored.
- Simultaneous `in_stop` and frame end: no loop restart; go to IDLE.

## Timing
- `out_display`, `out_busy`, and `out_plane` decode registered state only, with no combinational path from any input.
- `out_next_plane` and `out_frame_done` are registered; each is high exactly one cycle.
- Start latency: `in_start` sampled at edge N; `out_busy` and `out_display` (when bright<CPT) are high from edge N.
- Plane p occupies exactly `CYCLES_PER_TICK << p` DISPLAY cycles. For `bright_l`=b, `out_display` is high for the first `(CPT-b)<<p` of them.
- `out_next_plane` rises in the same cycle WAIT is entered. If `in_continue` is already high, the earliest DISPLAY entry is the next edge, giving a minimum 1-cycle gap per plane.
- Single frame with `in_continue` tied high: `CPT*(2^PLANES - 1) + (PLANES-1)` cycles from start to the `out_frame_done` cycle inclusive.
- `rst` mid-operation: at the next edge all registers take their reset values and the outputs are 0 in the following cycle. Pending requests are discarded.

## Test plan
All scenarios use PLANES=3, CPT=4.
- Start, bright=0, `in_continue` high: `out_display` is high for 4, 8, and 16 cycles, separated by one low cycle. `out_next_plane` pulses with plane=1, then plane=2. `out_frame_done` pulses on the 30th busy cycle, then the block returns to IDLE.
- bright=1: `out_display` is high 3/4, 6/8, 12/16 of each slot, with the low cycles at the slot ends. Slot lengths are unchanged.
- `in_continue` delayed 5 cycles after the plane-1 request: WAIT holds 5 cycles with `out_display`=0 and timer 0. DISPLAY then resumes with the full 8-cycle slot.
- `in_loop`=1 and brightness changed mid-frame: the new value applies only after `out_frame_done`, and plane resets to 0 with a request pulse. An `in_stop` pulse mid-frame-2 lets frame 2 finish, then `out_busy` falls.
- brightness=9 (over CPT): `out_display` is never high; the frame still takes 30 cycles.
- `rst` asserted mid-DISPLAY of plane 2: the next cycle shows IDLE with all outputs 0. A later `in_start` restarts from plane 0.

Source files
------------

// File: rtl/bcm_plane_sequencer_if.sv
// rtl/bcm_plane_sequencer_if.sv - control and plane-loader handshake bundle for the BCM sequencer
interface bcm_plane_sequencer_if #(
  parameter int BRIGHT_W = 9,
  parameter int PIDX_W   = 2
);
  logic                in_start;
  logic                in_loop;
  logic                in_stop;
  logic [BRIGHT_W-1:0] in_brightness;
  logic                in_continue;
  logic [PIDX_W-1:0]   out_plane;
  logic                out_next_plane;
  logic                out_display;
  logic                out_busy;
  logic                out_frame_done;

  modport master (
    output in_start, in_loop, in_stop, in_brightness, in_continue,
    input  out_plane, out_next_plane, out_display, out_busy, out_frame_done
  );

  modport slave (
    input  in_start, in_loop, in_stop, in_brightness, in_continue,
    output out_plane, out_next_plane, out_display, out_busy, out_frame_done
  );
endinterface

// File: rtl/bcm_plane_sequencer.sv
// rtl/bcm_plane_sequencer.sv - binary-code-modulation plane timer with dimmed output-enable
module bcm_plane_sequencer #(
  parameter int PLANES          = 4,
  parameter int CYCLES_PER_TICK = 256,
  parameter int BRIGHT_W        = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  bcm_plane_sequencer_if.slave  bus
);
  localparam int SLOT_MAX = CYCLES_PER_TICK << (PLANES - 1);
  localparam int TIMER_W  = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int PIDX_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
  // One spare bit so the longest slot length itself is representable in compares.
  localparam int CMP_W    = TIMER_W + 1;
  localparam logic [PIDX_W-1:0] LAST     = PIDX_W'(PLANES - 1);
  localparam logic [CMP_W-1:0]  CPT      = CMP_W'(CYCLES_PER_TICK);
  localparam logic [CMP_W-1:0]  LAST_END = CMP_W'(SLOT_MAX - 1);

  typedef enum logic [1:0] {IDLE, DISPLAY, WAIT} state_t;

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic [PIDX_W-1:0]   plane, plane_n;
  logic [CMP_W-1:0]    bright_l, bright_n, bright_clamp;
  logic [CMP_W-1:0]    slot_len, on_len;
  logic                stop_pend, stop_n;
  logic                req_q, req_n, done_q, done_n;
  logic                slot_end;

  always_comb begin
    bright_clamp = CPT;
    if (32'(bus.in_brightness) < 32'(CYCLES_PER_TICK))
      bright_clamp = CMP_W'(bus.in_brightness);
  end

  assign slot_len = CPT << plane;
  assign on_len   = (CPT - bright_l) << plane;
  assign slot_end = ({1'b0, timer} == slot_len - CMP_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      plane     <= '0;
      bright_l  <= '0;
      stop_pend <= 1'b0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      plane     <= plane_n;
      bright_l  <= bright_n;
      stop_pend <= stop_n;
      req_q     <= req_n;
      done_q    <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    plane_n  = plane;
    bright_n = bright_l;
    stop_n   = stop_pend;
    req_n    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_start) begin
          state_n  = DISPLAY;
          timer_n  = '0;
          plane_n  = '0;
          bright_n = bright_clamp;
          stop_n   = 1'b0;
        end
      end
      DISPLAY: begin
        stop_n  = stop_pend | bus.in_stop;
        timer_n = timer + TIMER_W'(1);
        if (slot_end) begin
          timer_n = '0;
          if (plane != LAST) begin
            plane_n = plane + PIDX_W'(1);
            req_n   = 1'b1;
            state_n = WAIT;
          end else if (bus.in_loop && !stop_pend && !bus.in_stop) begin
            plane_n  = '0;
            bright_n = bright_clamp;
            req_n    = 1'b1;
            state_n  = WAIT;
          end else begin
            state_n = IDLE;
            stop_n  = 1'b0;
          end
        end
      end
      WAIT: begin
        stop_n = stop_pend | bus.in_stop;
        if (bus.in_continue)
          state_n = DISPLAY;
      end
      default: state_n = IDLE;
    endcase
    // Look one cycle ahead so the pulse lands on the last display cycle of the frame.
    done_n = (state_n == DISPLAY) && (plane_n == LAST) && ({1'b0, timer_n} == LAST_END);
  end

  always_comb begin
    bus.out_busy    = (state != IDLE);
    bus.out_display = (state == DISPLAY) && ({1'b0, timer} < on_len);
  end

  assign bus.out_plane      = plane;
  assign bus.out_next_plane = req_q;
  assign bus.out_frame_done = done_q;
endmodule

// File: tb/tb_bcm_plane_sequencer.sv
// tb/tb_bcm_plane_sequencer.sv - directed self-checking bench for bcm_plane_sequencer (PLANES=3, CPT=4)
module tb_bcm_plane_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  bcm_plane_sequencer_if #(.BRIGHT_W(9), .PIDX_W(2)) bus ();

  bcm_plane_sequencer #(.PLANES(3), .CYCLES_PER_TICK(4), .BRIGHT_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit         tr_disp [0:79];
  bit         tr_busy [0:79];
  bit         tr_np   [0:79];
  bit         tr_fd   [0:79];
  logic [1:0] tr_plane[0:79];
  bit         ex_disp [0:29];
  bit         ex_np   [0:29];
  bit         ex_fd   [0:29];
  logic [1:0] ex_plane[0:29];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected 30-cycle frame trace with in_continue held high.
  function automatic void build_expected(input int b);
    int bb = (b > 4) ? 4 : b;
    int k = 0;
    for (int p = 0; p < 3; p++) begin
      for (int t = 0; t < (4 << p); t++) begin
        ex_disp[k]  = (t < ((4 - bb) << p));
        ex_np[k]    = 1'b0;
        ex_fd[k]    = (p == 2) && (t == 15);
        ex_plane[k] = 2'(p);
        k++;
      end
      if (p < 2) begin
        ex_disp[k]  = 1'b0;
        ex_np[k]    = 1'b1;
        ex_fd[k]    = 1'b0;
        ex_plane[k] = 2'(p + 1);
        k++;
      end
    end
  endfunction

  task automatic start_frame();
    bus.in_start = 1'b1;
    step();
    bus.in_start = 1'b0;
  endtask

  task automatic capture(input int n, input int bright_at, input int bright_val, input int stop_at);
    for (int k = 0; k < n; k++) begin
      if (k == bright_at) bus.in_brightness = 9'(bright_val);
      bus.in_stop = (k == stop_at);
      tr_disp[k]  = bus.out_display;
      tr_busy[k]  = bus.out_busy;
      tr_np[k]    = bus.out_next_plane;
      tr_fd[k]    = bus.out_frame_done;
      tr_plane[k] = bus.out_plane;
      step();
    end
    bus.in_stop = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.out_busy && n < 100) begin
      step();
      n++;
    end
    total++;
    if (bus.out_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle timeout busy got %0b want 0", name, bus.out_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if ({bus.out_display, bus.out_busy, bus.out_next_plane, bus.out_frame_done, bus.out_plane} !== 6'b0) begin
      bad++;
      $display("FAIL reset outputs got %b want 000000",
               {bus.out_display, bus.out_busy, bus.out_next_plane, bus.out_frame_done, bus.out_plane});
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.out_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset idle busy got %0b want 0", bus.out_busy);
    end
  endtask

  task automatic test_frame(input int b, input string name);
    bus.in_brightness = 9'(b);
    bus.in_continue   = 1'b1;
    bus.in_loop       = 1'b0;
    build_expected(b);
    start_frame();
    capture(31, -1, 0, -1);
    for (int k = 0; k < 30; k++) begin
      total++;
      if (tr_disp[k] !== ex_disp[k] || tr_busy[k] !== 1'b1 || tr_np[k] !== ex_np[k] ||
          tr_fd[k] !== ex_fd[k] || tr_plane[k] !== ex_plane[k]) begin
        bad++;
        $display("FAIL %s cycle %0d disp/busy/np/fd/plane got %0b%0b%0b%0b/%0d want %0b1%0b%0b/%0d",
                 name, k + 1, tr_disp[k], tr_busy[k], tr_np[k], tr_fd[k], tr_plane[k],
                 ex_disp[k], ex_np[k], ex_fd[k], ex_plane[k]);
      end
    end
    total++;
    if (tr_busy[30] !== 1'b0 || tr_disp[30] !== 1'b0 || tr_fd[30] !== 1'b0) begin
      bad++;
      $display("FAIL %s end busy/disp/fd got %0b%0b%0b want 000", name, tr_busy[30], tr_disp[30], tr_fd[30]);
    end
  endtask

  task automatic test_wait_delay();
    bus.in_brightness = 9'd0;
    bus.in_continue   = 1'b0;
    bus.in_loop       = 1'b0;
    start_frame();
    repeat (4) step();
    total++;
    if (bus.out_next_plane !== 1'b1 || bus.out_plane !== 2'd1 || bus.out_display !== 1'b0) begin
      bad++;
      $display("FAIL wait_req np/plane/disp got %0b/%0d/%0b want 1/1/0",
               bus.out_next_plane, bus.out_plane, bus.out_display);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.out_display !== 1'b0 || bus.out_busy !== 1'b1 || dut.timer !== '0 ||
          bus.out_plane !== 2'd1 || (i > 0 && bus.out_next_plane !== 1'b0)) begin
        bad++;
        $display("FAIL wait_hold %0d disp/busy/timer/plane/np got %0b/%0b/%0d/%0d/%0b want 0/1/0/1/x",
                 i, bus.out_display, bus.out_busy, dut.timer, bus.out_plane, bus.out_next_plane);
      end
      if (i == 4) bus.in_continue = 1'b1;
      step();
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus.out_display !== 1'b1 || bus.out_plane !== 2'd1) begin
        bad++;
        $display("FAIL wait_resume %0d disp/plane got %0b/%0d want 1/1", i, bus.out_display, bus.out_plane);
      end
      step();
    end
    total++;
    if (bus.out_display !== 1'b0 || bus.out_next_plane !== 1'b1 || bus.out_plane !== 2'd2) begin
      bad++;
      $display("FAIL wait_next disp/np/plane got %0b/%0b/%0d want 0/1/2",
               bus.out_display, bus.out_next_plane, bus.out_plane);
    end
    wait_idle("wait_delay");
  endtask

  task automatic test_loop_stop();
    bus.in_brightness = 9'd0;
    bus.in_continue   = 1'b1;
    bus.in_loop       = 1'b1;
    start_frame();
    capture(64, 10, 2, 40);
    build_expected(0);
    for (int k = 0; k < 30; k++) begin
      total++;
      if (tr_disp[k] !== ex_disp[k] || tr_fd[k] !== ex_fd[k]) begin
        bad++;
        $display("FAIL loop_f1 cycle %0d disp/fd got %0b%0b want %0b%0b", k + 1, tr_disp[k], tr_fd[k], ex_disp[k], ex_fd[k]);
      end
    end
    total++;
    if (tr_np[30] !== 1'b1 || tr_plane[30] !== 2'd0 || tr_disp[30] !== 1'b0 || tr_busy[30] !== 1'b1 || tr_fd[30] !== 1'b0) begin
      bad++;
      $display("FAIL loop_restart np/plane/disp/busy/fd got %0b/%0d/%0b/%0b/%0b want 1/0/0/1/0",
               tr_np[30], tr_plane[30], tr_disp[30], tr_busy[30], tr_fd[30]);
    end
    build_expected(2);
    for (int k = 0; k < 30; k++) begin
      total++;
      if (tr_disp[31+k] !== ex_disp[k] || tr_fd[31+k] !== ex_fd[k] || tr_np[31+k] !== ex_np[k] ||
          tr_plane[31+k] !== ex_plane[k] || tr_busy[31+k] !== 1'b1) begin
        bad++;
        $display("FAIL loop_f2 cycle %0d disp/fd/np/plane got %0b%0b%0b/%0d want %0b%0b%0b/%0d",
                 k + 1, tr_disp[31+k], tr_fd[31+k], tr_np[31+k], tr_plane[31+k],
                 ex_disp[k], ex_fd[k], ex_np[k], ex_plane[k]);
      end
    end
    total++;
    if (tr_busy[61] !== 1'b0 || tr_np[61] !== 1'b0) begin
      bad++;
      $display("FAIL loop_stop busy/np got %0b/%0b want 0/0", tr_busy[61], tr_np[61]);
    end
    bus.in_loop = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.in_brightness = 9'd0;
    bus.in_continue   = 1'b1;
    bus.in_loop       = 1'b0;
    start_frame();
    repeat (19) step();
    total++;
    if (bus.out_plane !== 2'd2 || bus.out_display !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre plane/disp got %0d/%0b want 2/1", bus.out_plane, bus.out_display);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({bus.out_display, bus.out_busy, bus.out_next_plane, bus.out_frame_done, bus.out_plane} !== 6'b0) begin
      bad++;
      $display("FAIL rstmid outputs got %b want 000000",
               {bus.out_display, bus.out_busy, bus.out_next_plane, bus.out_frame_done, bus.out_plane});
    end
    step();
    start_frame();
    total++;
    if (bus.out_display !== 1'b1 || bus.out_busy !== 1'b1 || bus.out_plane !== 2'd0) begin
      bad++;
      $display("FAIL rstmid_restart disp/busy/plane got %0b/%0b/%0d want 1/1/0",
               bus.out_display, bus.out_busy, bus.out_plane);
    end
    repeat (4) step();
    total++;
    if (bus.out_next_plane !== 1'b1 || bus.out_plane !== 2'd1) begin
      bad++;
      $display("FAIL rstmid_req np/plane got %0b/%0d want 1/1", bus.out_next_plane, bus.out_plane);
    end
    wait_idle("reset_mid");
  endtask

  initial begin
    bus.in_start      = 1'b0;
    bus.in_loop       = 1'b0;
    bus.in_stop       = 1'b0;
    bus.in_brightness = 9'd0;
    bus.in_continue   = 1'b0;
    test_reset();
    test_frame(0, "bright0");
    test_frame(1, "bright1");
    test_frame(9, "bright9");
    test_wait_delay();
    test_loop_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
